// File: rtl/register_stack_controller.sv
// LIFO operand-stack controller: DEPTH x WIDTH register bank with one op per handshake,
// top/next visibility for the ALU, and sticky overflow/underflow fault flags.
module register_stack_controller #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 16,
  parameter int DEPTH_W = $clog2(DEPTH)
) (
  input  logic               in_clk,
  input  logic               in_reset_n,
  input  logic               in_op_valid,
  input  logic [2:0]         in_op,
  input  logic [WIDTH-1:0]   in_push_value,
  input  logic               in_clear_err,
  output logic               ot_op_ready,
  output logic               ot_done,
  output logic               ot_fault,
  output logic [WIDTH-1:0]   ot_pop_value,
  output logic [WIDTH-1:0]   ot_top,
  output logic [WIDTH-1:0]   ot_next,
  output logic [DEPTH_W:0]   ot_depth,
  output logic               ot_full,
  output logic               ot_empty,
  output logic               ot_overflow,
  output logic               ot_underflow
);

  typedef enum logic {IDLE, SWAP_WB} state_t;

  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_DUP   = 3'b011;
  localparam logic [2:0] OP_SWAP  = 3'b100;
  localparam logic [2:0] OP_OVER  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  localparam logic [DEPTH_W:0] ONE     = (DEPTH_W+1)'(1);
  localparam logic [DEPTH_W:0] TWO     = (DEPTH_W+1)'(2);
  localparam logic [DEPTH_W:0] DEPTH_L = (DEPTH_W+1)'(DEPTH);

  state_t             state;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [WIDTH-1:0]   temp;
  logic [DEPTH_W:0]   depth;
  logic [DEPTH_W:0]   depth_m1;
  logic [DEPTH_W:0]   depth_m2;
  logic [DEPTH_W-1:0] top_idx;
  logic [DEPTH_W-1:0] next_idx;
  logic [DEPTH_W-1:0] push_idx;
  logic               is_empty;
  logic               is_full;
  logic               lt2;
  logic [WIDTH-1:0]   top_val;
  logic [WIDTH-1:0]   next_val;
  logic               accept;
  logic               op_ovf;
  logic               op_unf;

  // Slot indices are only used when the matching depth guard holds, so truncation is safe.
  assign depth_m1 = depth - ONE;
  assign depth_m2 = depth - TWO;
  assign top_idx  = depth_m1[DEPTH_W-1:0];
  assign next_idx = depth_m2[DEPTH_W-1:0];
  assign push_idx = depth[DEPTH_W-1:0];

  assign is_empty = (depth == '0);
  assign is_full  = (depth == DEPTH_L);
  assign lt2      = (depth < TWO);
  assign top_val  = is_empty ? '0 : mem[top_idx];
  assign next_val = lt2 ? '0 : mem[next_idx];

  assign accept      = in_op_valid && (state == IDLE);
  assign ot_op_ready = (state == IDLE);
  assign ot_top      = top_val;
  assign ot_next     = next_val;
  assign ot_depth    = depth;
  assign ot_full     = is_full;
  assign ot_empty    = is_empty;

  always_comb begin
    op_ovf = 1'b0;
    op_unf = 1'b0;
    case (in_op)
      OP_PUSH: op_ovf = is_full;
      OP_POP:  op_unf = is_empty;
      OP_DUP: begin
        op_unf = is_empty;
        op_ovf = is_full;
      end
      OP_SWAP: op_unf = lt2;
      OP_OVER: begin
        op_unf = lt2;
        op_ovf = is_full;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state        <= IDLE;
      depth        <= '0;
      temp         <= '0;
      ot_pop_value <= '0;
      ot_done      <= 1'b0;
      ot_fault     <= 1'b0;
      ot_overflow  <= 1'b0;
      ot_underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ot_done  <= 1'b0;
      ot_fault <= 1'b0;
      // A fresh fault outranks a simultaneous clear request.
      ot_overflow  <= (accept && op_ovf) || (ot_overflow && !in_clear_err);
      ot_underflow <= (accept && op_unf) || (ot_underflow && !in_clear_err);
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_ovf || op_unf) begin
              ot_done  <= 1'b1;
              ot_fault <= 1'b1;
            end else begin
              ot_done <= (in_op != OP_SWAP);
              case (in_op)
                OP_PUSH: begin
                  mem[push_idx] <= in_push_value;
                  depth         <= depth + ONE;
                end
                OP_POP: begin
                  ot_pop_value <= top_val;
                  depth        <= depth - ONE;
                end
                OP_DUP: begin
                  mem[push_idx] <= top_val;
                  depth         <= depth + ONE;
                end
                OP_OVER: begin
                  mem[push_idx] <= next_val;
                  depth         <= depth + ONE;
                end
                OP_SWAP: begin
                  temp         <= top_val;
                  mem[top_idx] <= next_val;
                  state        <= SWAP_WB;
                end
                OP_CLEAR: depth <= '0;
                default: ;
              endcase
            end
          end
        end
        SWAP_WB: begin
          mem[next_idx] <= temp;
          ot_done       <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_stack_controller.sv
// Table-driven bench for register_stack_controller with hand-computed expected values,
// plus a hand-written sequence for reset asserted in the middle of a SWAP.
module tb_register_stack_controller;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] PUSH  = 3'b001;
  localparam logic [2:0] POP   = 3'b010;
  localparam logic [2:0] DUP   = 3'b011;
  localparam logic [2:0] SWAP  = 3'b100;
  localparam logic [2:0] OVER  = 3'b101;
  localparam logic [2:0] CLR   = 3'b110;
  localparam logic [2:0] RSV   = 3'b111;

  logic        in_clk;
  logic        in_reset_n;
  logic        in_op_valid;
  logic [2:0]  in_op;
  logic [15:0] in_push_value;
  logic        in_clear_err;
  logic        ot_op_ready;
  logic        ot_done;
  logic        ot_fault;
  logic [15:0] ot_pop_value;
  logic [15:0] ot_top;
  logic [15:0] ot_next;
  logic [3:0]  ot_depth;
  logic        ot_full;
  logic        ot_empty;
  logic        ot_overflow;
  logic        ot_underflow;

  register_stack_controller #(.DEPTH(8), .WIDTH(16)) dut (
    .in_clk        (in_clk),
    .in_reset_n    (in_reset_n),
    .in_op_valid   (in_op_valid),
    .in_op         (in_op),
    .in_push_value (in_push_value),
    .in_clear_err  (in_clear_err),
    .ot_op_ready   (ot_op_ready),
    .ot_done       (ot_done),
    .ot_fault      (ot_fault),
    .ot_pop_value  (ot_pop_value),
    .ot_top        (ot_top),
    .ot_next       (ot_next),
    .ot_depth      (ot_depth),
    .ot_full       (ot_full),
    .ot_empty      (ot_empty),
    .ot_overflow   (ot_overflow),
    .ot_underflow  (ot_underflow)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic [15:0] val;
    logic        clr;
    logic        rdy;
    logic        done;
    logic        fault;
    logic [3:0]  depth;
    logic [15:0] top;
    logic [15:0] nxt;
    logic        ov;
    logic        un;
    logic [15:0] pop;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_err;

  function automatic vec_t mk(logic v, logic [2:0] op, logic [15:0] val, logic clr,
                              logic rdy, logic done, logic fault, logic [3:0] depth,
                              logic [15:0] top, logic [15:0] nxt, logic ov, logic un,
                              logic [15:0] pop);
    vec_t r;
    r.v = v; r.op = op; r.val = val; r.clr = clr;
    r.rdy = rdy; r.done = done; r.fault = fault; r.depth = depth;
    r.top = top; r.nxt = nxt; r.ov = ov; r.un = un; r.pop = pop;
    return r;
  endfunction

  // Expected bundle: full and empty follow directly from the expected depth.
  function automatic logic [58:0] pack_exp(logic rdy, logic done, logic fault, logic [3:0] depth,
                                           logic [15:0] top, logic [15:0] nxt, logic ov,
                                           logic un, logic [15:0] pop);
    return {rdy, done, fault, depth, (depth == 4'd8), (depth == 4'd0), top, nxt, ov, un, pop};
  endfunction

  function automatic logic [58:0] pack_act();
    return {ot_op_ready, ot_done, ot_fault, ot_depth, ot_full, ot_empty,
            ot_top, ot_next, ot_overflow, ot_underflow, ot_pop_value};
  endfunction

  task automatic chk(input string name, input logic [58:0] exp);
    logic [58:0] act;
    act = pack_act();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rdy=%b done=%b fault=%b depth=%0d full=%b empty=%b top=%h next=%h ov=%b un=%b pop=%h | want %h (got %h)",
               name, ot_op_ready, ot_done, ot_fault, ot_depth, ot_full, ot_empty,
               ot_top, ot_next, ot_overflow, ot_underflow, ot_pop_value, exp, act);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] val, input logic clr);
    in_op_valid   = v;
    in_op         = op;
    in_push_value = val;
    in_clear_err  = clr;
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    in_reset_n = 1'b0;
    drive(1'b0, NOP, 16'h0, 1'b0);

    //  v  op    val       clr  rdy done flt dep top       next      ov un pop
    tbl.push_back(mk(1, PUSH, 16'h1111, 0, 1, 1, 0, 1, 16'h1111, 16'h0000, 0, 0, 16'h0000));
    tbl.push_back(mk(1, PUSH, 16'h2222, 0, 1, 1, 0, 2, 16'h2222, 16'h1111, 0, 0, 16'h0000));
    tbl.push_back(mk(1, PUSH, 16'h3333, 0, 1, 1, 0, 3, 16'h3333, 16'h2222, 0, 0, 16'h0000));
    tbl.push_back(mk(1, SWAP, 16'h0000, 0, 0, 0, 0, 3, 16'h2222, 16'h2222, 0, 0, 16'h0000));
    tbl.push_back(mk(1, PUSH, 16'hBEEF, 0, 1, 1, 0, 3, 16'h2222, 16'h3333, 0, 0, 16'h0000));
    tbl.push_back(mk(1, POP,  16'h0000, 0, 1, 1, 0, 2, 16'h3333, 16'h1111, 0, 0, 16'h2222));
    tbl.push_back(mk(0, PUSH, 16'h7777, 0, 1, 0, 0, 2, 16'h3333, 16'h1111, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h0004, 0, 1, 1, 0, 3, 16'h0004, 16'h3333, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h0005, 0, 1, 1, 0, 4, 16'h0005, 16'h0004, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h0006, 0, 1, 1, 0, 5, 16'h0006, 16'h0005, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h0007, 0, 1, 1, 0, 6, 16'h0007, 16'h0006, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h0008, 0, 1, 1, 0, 7, 16'h0008, 16'h0007, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h0009, 0, 1, 1, 0, 8, 16'h0009, 16'h0008, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'hDEAD, 0, 1, 1, 1, 8, 16'h0009, 16'h0008, 1, 0, 16'h2222));
    tbl.push_back(mk(1, DUP,  16'h0000, 0, 1, 1, 1, 8, 16'h0009, 16'h0008, 1, 0, 16'h2222));
    tbl.push_back(mk(0, NOP,  16'h0000, 1, 1, 0, 0, 8, 16'h0009, 16'h0008, 0, 0, 16'h2222));
    tbl.push_back(mk(1, OVER, 16'h0000, 1, 1, 1, 1, 8, 16'h0009, 16'h0008, 1, 0, 16'h2222));
    tbl.push_back(mk(0, NOP,  16'h0000, 1, 1, 0, 0, 8, 16'h0009, 16'h0008, 0, 0, 16'h2222));
    tbl.push_back(mk(1, CLR,  16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h2222));
    tbl.push_back(mk(1, POP,  16'h0000, 0, 1, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 16'h2222));
    tbl.push_back(mk(1, SWAP, 16'h0000, 0, 1, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h00AB, 0, 1, 1, 0, 1, 16'h00AB, 16'h0000, 0, 1, 16'h2222));
    tbl.push_back(mk(1, OVER, 16'h0000, 0, 1, 1, 1, 1, 16'h00AB, 16'h0000, 0, 1, 16'h2222));
    tbl.push_back(mk(0, NOP,  16'h0000, 1, 1, 0, 0, 1, 16'h00AB, 16'h0000, 0, 0, 16'h2222));
    tbl.push_back(mk(1, DUP,  16'h0000, 0, 1, 1, 0, 2, 16'h00AB, 16'h00AB, 0, 0, 16'h2222));
    tbl.push_back(mk(1, SWAP, 16'h0000, 0, 0, 0, 0, 2, 16'h00AB, 16'h00AB, 0, 0, 16'h2222));
    tbl.push_back(mk(0, NOP,  16'h0000, 0, 1, 1, 0, 2, 16'h00AB, 16'h00AB, 0, 0, 16'h2222));
    tbl.push_back(mk(1, PUSH, 16'h1234, 0, 1, 1, 0, 3, 16'h1234, 16'h00AB, 0, 0, 16'h2222));
    tbl.push_back(mk(1, OVER, 16'h0000, 0, 1, 1, 0, 4, 16'h00AB, 16'h1234, 0, 0, 16'h2222));
    tbl.push_back(mk(1, POP,  16'h0000, 0, 1, 1, 0, 3, 16'h1234, 16'h00AB, 0, 0, 16'h00AB));
    tbl.push_back(mk(1, RSV,  16'hFFFF, 0, 1, 1, 0, 3, 16'h1234, 16'h00AB, 0, 0, 16'h00AB));
    tbl.push_back(mk(1, CLR,  16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h00AB));
    tbl.push_back(mk(1, DUP,  16'h0000, 0, 1, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 16'h00AB));
    tbl.push_back(mk(0, NOP,  16'h0000, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h00AB));

    repeat (3) @(posedge in_clk);
    #1;
    chk("reset_held", pack_exp(1, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 16'h0));
    in_reset_n = 1'b1;
    tick();
    chk("reset_released", pack_exp(1, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 16'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].val, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d", i),
          pack_exp(tbl[i].rdy, tbl[i].done, tbl[i].fault, tbl[i].depth,
                   tbl[i].top, tbl[i].nxt, tbl[i].ov, tbl[i].un, tbl[i].pop));
    end

    // Reset asserted while the SWAP write-back is pending.
    drive(1'b1, PUSH, 16'h0A0A, 1'b0);
    tick();
    drive(1'b1, PUSH, 16'h0B0B, 1'b0);
    tick();
    drive(1'b1, SWAP, 16'h0000, 1'b0);
    tick();
    drive(1'b0, NOP, 16'h0000, 1'b0);
    chk("mid_swap_wb", pack_exp(0, 0, 0, 4'd2, 16'h0A0A, 16'h0A0A, 0, 0, 16'h00AB));
    #2;
    in_reset_n = 1'b0;
    #1;
    chk("async_reset_now", pack_exp(1, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 16'h0));
    @(posedge in_clk);
    #1;
    chk("reset_over_edge", pack_exp(1, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 16'h0));
    in_reset_n = 1'b1;
    tick();
    chk("after_release_1", pack_exp(1, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 16'h0));
    tick();
    chk("after_release_2", pack_exp(1, 0, 0, 4'd0, 16'h0, 16'h0, 0, 0, 16'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
